// File: rtl/wfg_subcore_multi.sv
// Multi-channel timing core: one shared subcycle tick from clk, NCH sync ticks from the subcycle tick,
// each with its own divider and initial phase, in continuous or burst mode.
module wfg_subcore_multi #(
  parameter int NCH    = 2,
  parameter int SUBW   = 16,
  parameter int SYNCW  = 8,
  parameter int CNTW   = 8,
  parameter int BURSTW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [BURSTW-1:0]     burst_len_i,
  input  logic [SUBW-1:0]       wfg_subcycle_count_i,
  input  logic [NCH*SYNCW-1:0]  wfg_sync_count_i,
  input  logic [NCH*SYNCW-1:0]  wfg_sync_phase_i,
  output logic                  wfg_subcore_start_o,
  output logic                  wfg_subcore_subcycle_o,
  output logic [NCH-1:0]        wfg_subcore_sync_o,
  output logic [NCH*CNTW-1:0]   wfg_subcore_subcycle_cnt_o,
  output logic                  active_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_mode;
  logic [BURSTW-1:0] r_burst_len;
  logic [SUBW-1:0]   r_sub_shadow;
  logic [SYNCW-1:0]  r_sync_shadow [NCH];

  logic [SUBW-1:0]   r_sub_cnt;
  logic [SYNCW-1:0]  r_sync_cnt [NCH];
  logic [CNTW-1:0]   r_pcnt [NCH];
  logic [BURSTW-1:0] r_burst_cnt;

  logic              r_start;
  logic              r_subcycle;
  logic [NCH-1:0]    r_sync;

  logic              w_tick;
  logic              w_sync0;
  logic [BURSTW-1:0] w_burst_nxt;
  logic              w_burst_hit;

  always_comb begin
    w_tick      = (r_state == S_RUN) && (r_sub_cnt == '0);
    w_sync0     = w_tick && (r_sync_cnt[0] == '0);
    w_burst_nxt = (r_burst_cnt == '1) ? r_burst_cnt : r_burst_cnt + 1'b1;
    // The ch0 sync that completes the burst is still emitted on this edge.
    w_burst_hit = w_sync0 && r_mode && (r_burst_len != '0) && (w_burst_nxt == r_burst_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (en_i) w_next_state = S_RUN;
      S_RUN: begin
        if (!en_i)            w_next_state = S_IDLE;
        else if (w_burst_hit) w_next_state = S_DONE;
      end
      S_DONE:  if (!en_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= 1'b0;
      r_burst_len  <= '0;
      r_sub_shadow <= '0;
      r_sub_cnt    <= '0;
      r_burst_cnt  <= '0;
      r_start      <= 1'b0;
      r_subcycle   <= 1'b0;
      r_sync       <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_sync_shadow[i] <= '0;
        r_sync_cnt[i]    <= '0;
        r_pcnt[i]        <= '0;
      end
    end else if ((r_state != S_IDLE) && !en_i) begin
      r_sub_cnt   <= '0;
      r_burst_cnt <= '0;
      r_start     <= 1'b0;
      r_subcycle  <= 1'b0;
      r_sync      <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_sync_cnt[i] <= '0;
        r_pcnt[i]     <= '0;
      end
    end else if ((r_state == S_IDLE) && en_i) begin
      // Configuration is frozen here; inputs are ignored until the next enable.
      r_mode       <= mode_i;
      r_burst_len  <= burst_len_i;
      r_sub_shadow <= wfg_subcycle_count_i;
      r_sub_cnt    <= '0;
      r_burst_cnt  <= '0;
      r_start      <= 1'b1;
      r_subcycle   <= 1'b0;
      r_sync       <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_sync_shadow[i] <= wfg_sync_count_i[i*SYNCW +: SYNCW];
        r_sync_cnt[i]    <= wfg_sync_phase_i[i*SYNCW +: SYNCW];
        r_pcnt[i]        <= '0;
      end
    end else begin
      r_start    <= 1'b0;
      r_subcycle <= 1'b0;
      r_sync     <= '0;
      if (w_tick) begin
        r_sub_cnt  <= r_sub_shadow;
        r_subcycle <= 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (r_sync_cnt[i] == '0) begin
            r_sync[i]     <= 1'b1;
            r_sync_cnt[i] <= r_sync_shadow[i];
            r_pcnt[i]     <= '0;
          end else begin
            r_sync_cnt[i] <= r_sync_cnt[i] - 1'b1;
            r_pcnt[i]     <= (r_pcnt[i] == '1) ? r_pcnt[i] : r_pcnt[i] + 1'b1;
          end
        end
        if (w_sync0) r_burst_cnt <= w_burst_nxt;
      end else if (r_state == S_RUN) begin
        r_sub_cnt <= r_sub_cnt - 1'b1;
      end
    end
  end

  assign wfg_subcore_start_o    = r_start;
  assign wfg_subcore_subcycle_o = r_subcycle;
  assign wfg_subcore_sync_o     = r_sync;
  assign active_o               = (r_state == S_RUN);
  assign done_o                 = (r_state == S_DONE);

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign wfg_subcore_subcycle_cnt_o[g*CNTW +: CNTW] = r_pcnt[g];
  end

endmodule

// File: tb/tb_wfg_subcore_multi.sv
// Bench for wfg_subcore_multi: directed scenarios plus randomized runs, checked every cycle against a
// closed-form timing model (pulse times derived from start edge, periods and phases).
module tb_wfg_subcore_multi;
  localparam int NCH    = 2;
  localparam int SUBW   = 16;
  localparam int SYNCW  = 8;
  localparam int CNTW   = 8;
  localparam int CNTW2  = 2;
  localparam int BURSTW = 8;
  localparam int W      = 4 + NCH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 mode = 1'b0;
  logic [BURSTW-1:0]    blen = '0;
  logic [SUBW-1:0]      subc = '0;
  logic [NCH*SYNCW-1:0] syncc = '0;
  logic [NCH*SYNCW-1:0] phase = '0;

  logic                 a_start, a_sub, a_active, a_done;
  logic [NCH-1:0]       a_sync;
  logic [NCH*CNTW-1:0]  a_cnt;
  logic                 b_start, b_sub, b_active, b_done;
  logic [NCH-1:0]       b_sync;
  logic [NCH*CNTW2-1:0] b_cnt;

  wfg_subcore_multi #(.NCH(NCH), .SUBW(SUBW), .SYNCW(SYNCW), .CNTW(CNTW), .BURSTW(BURSTW)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .burst_len_i(blen),
    .wfg_subcycle_count_i(subc), .wfg_sync_count_i(syncc), .wfg_sync_phase_i(phase),
    .wfg_subcore_start_o(a_start), .wfg_subcore_subcycle_o(a_sub), .wfg_subcore_sync_o(a_sync),
    .wfg_subcore_subcycle_cnt_o(a_cnt), .active_o(a_active), .done_o(a_done)
  );

  wfg_subcore_multi #(.NCH(NCH), .SUBW(SUBW), .SYNCW(SYNCW), .CNTW(CNTW2), .BURSTW(BURSTW)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .burst_len_i(blen),
    .wfg_subcycle_count_i(subc), .wfg_sync_count_i(syncc), .wfg_sync_phase_i(phase),
    .wfg_subcore_start_o(b_start), .wfg_subcore_subcycle_o(b_sub), .wfg_subcore_sync_o(b_sync),
    .wfg_subcore_subcycle_cnt_o(b_cnt), .active_o(b_active), .done_o(b_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: m_e counts edges since the enabling edge (0 = start edge).
  int m_run = 0;
  int m_e   = 0;
  int c_s, c_mode, c_len;
  int c_p  [NCH];
  int c_ph [NCH];

  function automatic int burst_on();
    return (c_mode != 0 && c_len != 0) ? 1 : 0;
  endfunction

  // Subcycle index at which the final ch0 sync of a burst lands.
  function automatic int kdone();
    return c_ph[0] + (c_len - 1) * (c_p[0] + 1);
  endfunction

  function automatic int ticks_so_far();
    int nt;
    if (!m_run || m_e < 1) return 0;
    nt = (m_e - 1) / (c_s + 1) + 1;
    if (burst_on() && nt > kdone() + 1) nt = kdone() + 1;
    return nt;
  endfunction

  function automatic int tick_now();
    if (!m_run || m_e < 1) return 0;
    if ((m_e - 1) % (c_s + 1) != 0) return 0;
    if (burst_on() && (m_e - 1) / (c_s + 1) > kdone()) return 0;
    return 1;
  endfunction

  function automatic int is_done();
    return (m_run && burst_on() && m_e >= 1 + kdone() * (c_s + 1)) ? 1 : 0;
  endfunction

  function automatic int exp_cnt(int ch, int maxv);
    int nt, kl, n;
    nt = ticks_so_far();
    if (nt == 0) return 0;
    kl = nt - 1;
    if (kl < c_ph[ch]) n = kl + 1;
    else               n = (kl - c_ph[ch]) % (c_p[ch] + 1);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [NCH-1:0] s;
    int k;
    s = '0;
    if (!m_run) return '0;
    k = (m_e - 1) / (c_s + 1);
    for (int i = 0; i < NCH; i++)
      if (tick_now() != 0 && k >= c_ph[i] && ((k - c_ph[i]) % (c_p[i] + 1)) == 0) s[i] = 1'b1;
    return {(m_e == 0), (tick_now() != 0), s, (is_done() == 0), (is_done() != 0)};
  endfunction

  task automatic model_update();
    if (!rst_n) m_run = 0;
    else if (!m_run) begin
      if (en) begin
        m_run  = 1;
        m_e    = 0;
        c_s    = int'(subc);
        c_mode = int'(mode);
        c_len  = int'(blen);
        for (int i = 0; i < NCH; i++) begin
          c_p[i]  = int'(syncc[i*SYNCW +: SYNCW]);
          c_ph[i] = int'(phase[i*SYNCW +: SYNCW]);
        end
      end
    end else if (!en) m_run = 0;
    else m_e++;
    exp_q.push_back(model_vec());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("start",    {31'd0, a_start},  {31'd0, e[W-1]});
    chk("subcycle", {31'd0, a_sub},    {31'd0, e[W-2]});
    chk("sync",     32'(a_sync),       32'(e[NCH+1:2]));
    chk("active",   {31'd0, a_active}, {31'd0, e[1]});
    chk("done",     {31'd0, a_done},   {31'd0, e[0]});
    chk("b_pulses", 32'({b_start, b_sub, b_sync, b_active, b_done}), 32'(e));
    for (int i = 0; i < NCH; i++) begin
      chk("cnt",   32'(a_cnt[i*CNTW +: CNTW]),   32'(exp_cnt(i, (1 << CNTW) - 1)));
      chk("cnt_b", 32'(b_cnt[i*CNTW2 +: CNTW2]), 32'(exp_cnt(i, (1 << CNTW2) - 1)));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive_cfg(input int s, input int p0, input int p1, input int ph0, input int ph1,
                           input int md, input int ln);
    subc  = SUBW'(s);
    syncc = {SYNCW'(p1), SYNCW'(p0)};
    phase = {SYNCW'(ph1), SYNCW'(ph0)};
    mode  = md[0];
    blen  = BURSTW'(ln);
  endtask

  initial begin
    // Reset held, then released away from the clock edge.
    run(3);
    rst_n = 1'b1;
    run(2);

    // Continuous, two channels with different periods and phases.
    drive_cfg(3, 1, 3, 0, 2, 0, 0);
    en = 1'b1;
    run(40);
    en = 1'b0;
    run(2);

    // Burst of 3, then burst mode with unlimited length.
    drive_cfg(0, 1, 0, 0, 0, 1, 3);
    en = 1'b1;
    run(12);
    en = 1'b0;
    run(1);
    drive_cfg(0, 1, 0, 0, 0, 1, 0);
    en = 1'b1;
    run(12);
    en = 1'b0;
    run(1);

    // Mid-run input change is ignored until re-enable.
    drive_cfg(3, 0, 1, 0, 1, 0, 0);
    en = 1'b1;
    run(6);
    subc = SUBW'(7);
    run(14);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(20);
    en = 1'b0;
    run(1);

    // Drop enable mid-run, then re-enable: phases restart.
    drive_cfg(1, 2, 1, 3, 1, 0, 0);
    en = 1'b1;
    run(9);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(15);

    // Asynchronous reset between edges while running.
    @(posedge clk);
    model_update();
    #2;
    rst_n = 1'b0;
    m_run = 0;
    exp_q.delete();
    exp_q.push_back(model_vec());
    #1;
    check_all();
    @(negedge clk);
    en = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);
    en = 1'b1;
    run(10);
    en = 1'b0;
    run(1);

    // Pulse-count saturation on the narrow-counter instance.
    drive_cfg(0, 7, 2, 0, 1, 0, 0);
    en = 1'b1;
    run(20);
    en = 1'b0;
    run(1);

    // Randomized configurations, with inputs scrambled during the run.
    for (int r = 0; r < 10; r++) begin
      drive_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1),
                $urandom_range(0, 4));
      en = 1'b1;
      run($urandom_range(10, 25));
      drive_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1),
                $urandom_range(0, 4));
      run($urandom_range(10, 25));
      en = 1'b0;
      run($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
